pps_monitor: RTL and testbench

Receive-side checker for the one-pulse-per-second (PPS) signal. It synchronises an incoming PPS and measures the rising-edge-to-rising-edge period and the high width of every pulse. It judges each pulse against a nominal period and reports lock, missing-pulse and error status to the clock controller. It sits on the PPS input path, ahead of the logic that delays and consumes PPS.

---
 rtl/pps_monitor.sv | 138 +++++++++++++
 tb/tb_pps_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pps_monitor.sv
// PPS receive checker: synchronises pps_in, measures period and high width of
// each pulse, and reports lock, missing-pulse and error status.
module pps_monitor #(
  parameter int CNT_W      = 20,
  parameter int NOMINAL    = 16667,
  parameter int TOL        = 16,
  parameter int MIN_WIDTH  = 8,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pps_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] width,
  output logic             sample_valid,
  output logic             sample_good,
  output logic             locked,
  output logic             missing,
  output logic [7:0]       err_count
);

  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0] WID_MIN = CNT_W'(MIN_WIDTH);
  localparam logic [7:0]       LOCK_N  = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  logic             pps_d, pps_d2;
  logic             rise, fall;
  logic [CNT_W-1:0] pcnt, wcnt;
  logic             wide_ok;
  state_t           state, state_nxt;
  logic             strobe, timeout, period_ok, good_nxt;
  logic [7:0]       streak, streak_nxt, err_nxt;

  // Synchroniser stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pps_d  <= 1'b0;
      pps_d2 <= 1'b0;
    end else begin
      pps_d  <= pps_in;
      pps_d2 <= pps_d;
    end
  end

  assign rise = pps_d & ~pps_d2;
  assign fall = ~pps_d & pps_d2;

  // Measurement stage: period and width counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt    <= '0;
      wcnt    <= '0;
      width   <= '0;
      wide_ok <= 1'b0;
    end else begin
      pcnt <= rise ? CNT_W'(1) : sat_inc_cnt(pcnt);
      if (rise)        wcnt <= CNT_W'(1);
      else if (pps_d2) wcnt <= sat_inc_cnt(wcnt);
      if (fall) begin
        width   <= wcnt;
        wide_ok <= (wcnt >= WID_MIN);
      end else if (rise) begin
        wide_ok <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    strobe     = 1'b0;
    timeout    = 1'b0;
    period_ok  = (pcnt >= PER_MIN) && (pcnt <= PER_MAX);
    good_nxt   = period_ok & wide_ok;
    case (state)
      IDLE:  if (rise) state_nxt = TRACK;
      TRACK: begin
        // A rise landing exactly on the threshold is a good period, not a timeout.
        if (rise) begin
          strobe = 1'b1;
        end else if (pcnt == PER_MAX) begin
          timeout   = 1'b1;
          state_nxt = LOST;
        end
      end
      LOST:    if (rise) state_nxt = TRACK;
      default: state_nxt = IDLE;
    endcase
    streak_nxt = streak;
    err_nxt    = err_count;
    if (strobe && good_nxt) begin
      streak_nxt = sat_inc8(streak);
    end else if (strobe || timeout) begin
      streak_nxt = 8'd0;
      err_nxt    = sat_inc8(err_count);
    end
  end

  // Verdict stage: registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      sample_valid <= 1'b0;
      sample_good  <= 1'b0;
      streak       <= 8'd0;
      locked       <= 1'b0;
      missing      <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      sample_valid <= strobe;
      streak       <= streak_nxt;
      locked       <= (streak_nxt >= LOCK_N);
      err_count    <= err_nxt;
      if (strobe) begin
        period      <= pcnt;
        sample_good <= good_nxt;
      end
      if (timeout)                     missing <= 1'b1;
      else if (state == LOST && rise)  missing <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pps_monitor.sv
// Directed bench for pps_monitor with NOMINAL=100, TOL=2, MIN_WIDTH=5, LOCK_COUNT=3.
module tb_pps_monitor;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          pps_in;
  logic [CW-1:0] period, width;
  logic          sample_valid, sample_good, locked, missing;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  pps_monitor #(
    .CNT_W(CW), .NOMINAL(100), .TOL(2), .MIN_WIDTH(5), .LOCK_COUNT(3)
  ) dut (
    .clk(clk), .rst(rst), .pps_in(pps_in),
    .period(period), .width(width),
    .sample_valid(sample_valid), .sample_good(sample_good),
    .locked(locked), .missing(missing), .err_count(err_count)
  );

  // hi: high cycles, per: cycles until the next rise; remaining fields are
  // what the row must observe (strobe count, strobed period/good/locked) and
  // the width, err_count and missing seen at the end of the row.
  typedef struct {
    int hi; int per; int sv; int pexp; int good; int lck; int wid; int err; int miss;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  logic last_sv  = 1'b0;
  vec_t tbl [15];

  function automatic vec_t mk(int hi, int per, int sv, int pexp, int good,
                              int lck, int wid, int err, int miss);
    vec_t v;
    v.hi = hi; v.per = per; v.sv = sv; v.pexp = pexp; v.good = good;
    v.lck = lck; v.wid = wid; v.err = err; v.miss = miss;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " period"}, period, 0);
    chk({tag, " width"}, width, 0);
    chk({tag, " sample_valid"}, sample_valid, 0);
    chk({tag, " sample_good"}, sample_good, 0);
    chk({tag, " locked"}, locked, 0);
    chk({tag, " missing"}, missing, 0);
    chk({tag, " err_count"}, err_count, 0);
  endtask

  task automatic apply_row(input vec_t v, input string tag);
    int            n;
    logic [CW-1:0] p;
    logic          g, l;
    n = 0; p = '0; g = 1'b0; l = 1'b0;
    pps_in = 1'b1;
    for (int i = 0; i < v.per; i++) begin
      if (i == v.hi) pps_in = 1'b0;
      tick();
      if (sample_valid) begin
        chk({tag, " sv_gap"}, last_sv, 0);
        n++;
        p = period; g = sample_good; l = locked;
      end
      last_sv = sample_valid;
    end
    chk({tag, " strobes"}, n, v.sv);
    if (v.sv != 0) begin
      chk({tag, " period"}, p, v.pexp);
      chk({tag, " good"}, g, v.good);
      chk({tag, " locked@strobe"}, l, v.lck);
    end else begin
      chk({tag, " locked"}, locked, v.lck);
    end
    chk({tag, " width"}, width, v.wid);
    chk({tag, " err_count"}, err_count, v.err);
    chk({tag, " missing"}, missing, v.miss);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            hi  per sv pexp g  L  wid err miss
    tbl[0]  = mk(10, 100, 0,   0, 0, 0, 10, 0, 0);
    tbl[1]  = mk(10, 100, 1, 100, 1, 0, 10, 0, 0);
    tbl[2]  = mk(10, 100, 1, 100, 1, 0, 10, 0, 0);
    tbl[3]  = mk(10,  97, 1, 100, 1, 1, 10, 0, 0);
    tbl[4]  = mk(10, 100, 1,  97, 0, 0, 10, 1, 0);
    tbl[5]  = mk(10, 102, 1, 100, 1, 0, 10, 1, 0);
    tbl[6]  = mk(10,  98, 1, 102, 1, 0, 10, 1, 0);
    tbl[7]  = mk(10, 100, 1,  98, 1, 1, 10, 1, 0);
    tbl[8]  = mk( 3, 100, 1, 100, 1, 1,  3, 1, 0);
    tbl[9]  = mk(10,  40, 1, 100, 0, 0, 10, 2, 0);
    tbl[10] = mk(10,  60, 1,  40, 0, 0, 10, 3, 0);
    tbl[11] = mk(10, 100, 1,  60, 0, 0, 10, 4, 0);
    tbl[12] = mk(10, 100, 1, 100, 1, 0, 10, 4, 0);
    tbl[13] = mk(10, 100, 1, 100, 1, 0, 10, 4, 0);
    tbl[14] = mk(10, 100, 1, 100, 1, 1, 10, 4, 0);

    rst    = 1'b0;
    pps_in = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b1;

    for (int r = 0; r < 15; r++) apply_row(tbl[r], $sformatf("row%0d", r));

    // Reset mid-pulse while locked with err_count=4
    pps_in = 1'b1;
    tick();
    tick();
    chk("pre_rst sample_valid", sample_valid, 1);
    chk("pre_rst period", period, 100);
    chk("pre_rst locked", locked, 1);
    chk("pre_rst err_count", err_count, 4);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    last_sv = 1'b0;
    apply_row(mk(10, 100, 0,   0, 0, 0, 10, 0, 0), "post0");
    apply_row(mk(10, 100, 1, 100, 1, 0, 10, 0, 0), "post1");
    apply_row(mk(10, 100, 1, 100, 1, 0, 10, 0, 0), "post2");
    apply_row(mk(10, 100, 1, 100, 1, 1, 10, 0, 0), "post3");

    // Pulse stops: timeout after 102 cycles without a rise
    repeat (3) tick();
    chk("stop missing_early", missing, 0);
    chk("stop locked_early", locked, 1);
    tick();
    chk("stop missing", missing, 1);
    chk("stop locked", locked, 0);
    chk("stop err_count", err_count, 1);
    repeat (20) tick();
    chk("stop sample_valid", sample_valid, 0);
    apply_row(mk(10, 100, 0,   0, 0, 0, 10, 1, 0), "resume0");
    apply_row(mk(10, 100, 1, 100, 1, 0, 10, 1, 0), "resume1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
